// File: rtl/w_pp_reader.sv
// w_pp_reader: read-side sequencer for the West ping-pong buffer.
// It waits for a full bank and replays it COL_Y times toward the matmul cores
// through a 2-entry skid FIFO. It then hands the bank back to the writer and
// moves to the other bank.
module w_pp_reader #(
   parameter  int unsigned WIDTH         = 16,
   parameter  int unsigned CHUNK_SIZE    = 4,
   parameter  int unsigned NUM_CORES_A   = 2,
   parameter  int unsigned NUM_CORES_B   = 2,
   parameter  int unsigned COL_X         = 4,
   parameter  int unsigned TOTAL_INPUT_W = 2,
   parameter  int unsigned COL_Y         = 4,
   localparam int unsigned MODULE_WIDTH  = WIDTH * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
   localparam int unsigned TOTAL_DEPTH   = COL_X * TOTAL_INPUT_W,
   localparam int unsigned ADDR_WIDTH    = $clog2(TOTAL_DEPTH),
   localparam int unsigned PASS_WIDTH    = $clog2(COL_Y)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              bank_full_i,
   output logic [1:0]              bank_release_o,
   output logic                    rd_en_o,
   output logic                    rd_bank_o,
   output logic [ADDR_WIDTH-1:0]   rd_addr_o,
   input  logic [MODULE_WIDTH-1:0] rd_data_i,
   output logic [MODULE_WIDTH-1:0] out_data_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic                    out_last_o,
   output logic [PASS_WIDTH-1:0]   out_pass_o,
   output logic                    busy_o
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] READ    = 2'd1;
   localparam logic [1:0] DRAIN   = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   logic [1:0]              state_q, state_nxt;
   logic                    cur_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [PASS_WIDTH-1:0]   pass_q;
   logic                    inflight_q;
   logic [PASS_WIDTH-1:0]   ifl_pass_q;
   logic                    ifl_last_q;
   logic [MODULE_WIDTH-1:0] fifo_data_q [2];
   logic [PASS_WIDTH-1:0]   fifo_pass_q [2];
   logic                    fifo_last_q [2];
   logic                    wr_ptr_q, rd_ptr_q;
   logic [1:0]              count_q;
   logic [1:0]              release_q;
   logic                    busy_q;
   logic                    pop, issue, addr_end, pass_end;

   // Handshake and read-issue decode: a read may be issued only if the FIFO
   // can still absorb it after this cycle's pop.
   assign addr_end    = (addr_q == ADDR_WIDTH'(TOTAL_DEPTH - 1));
   assign pass_end    = (pass_q == PASS_WIDTH'(COL_Y - 1));
   assign out_valid_o = (count_q != 2'd0);
   assign pop         = out_valid_o & out_ready_i;
   assign issue       = (state_q == READ) &&
                        ((3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

   assign rd_en_o        = issue;
   assign rd_bank_o      = cur_q;
   assign rd_addr_o      = addr_q;
   assign out_data_o     = fifo_data_q[rd_ptr_q];
   assign out_pass_o     = out_valid_o ? fifo_pass_q[rd_ptr_q] : '0;
   assign out_last_o     = out_valid_o & fifo_last_q[rd_ptr_q];
   assign bank_release_o = release_q;
   assign busy_o         = busy_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (bank_full_i[cur_q]) state_nxt = READ;
         READ:    if (issue && addr_end && pass_end) state_nxt = DRAIN;
         DRAIN:   if ((count_q == 2'd0) && !inflight_q) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bank pointer flips once the current bank has been handed back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cur_q <= 1'b0;
      else if (state_q == RELEASE) cur_q <= ~cur_q;
   end

   // Address/pass counters advance only on an issued read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         pass_q <= '0;
      end else if (issue) begin
         if (addr_end) begin
            addr_q <= '0;
            pass_q <= pass_end ? '0 : pass_q + PASS_WIDTH'(1);
         end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
         end
      end
   end

   // In-flight read tracking; tags travel alongside the one-cycle read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         ifl_pass_q <= '0;
         ifl_last_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            ifl_pass_q <= pass_q;
            ifl_last_q <= addr_end;
         end
      end
   end

   // 2-entry output FIFO, written with returning read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_pass_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (inflight_q) begin
            fifo_data_q[wr_ptr_q] <= rd_data_i;
            fifo_pass_q[wr_ptr_q] <= ifl_pass_q;
            fifo_last_q[wr_ptr_q] <= ifl_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         case ({inflight_q, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Registered status outputs, decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         release_q <= 2'b00;
         busy_q    <= 1'b0;
      end else begin
         busy_q    <= (state_nxt != IDLE);
         release_q <= (state_nxt == RELEASE) ? (cur_q ? 2'b10 : 2'b01) : 2'b00;
      end
   end

endmodule

// File: tb/tb_w_pp_reader.sv
// Directed bench for w_pp_reader: a bank memory model answers reads one cycle
// late. Each stream is checked word by word against the expected bank contents.
module tb_w_pp_reader;

   localparam int unsigned MW = 256;
   localparam int unsigned AW = 3;
   localparam int unsigned PW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    bank_full_i;
   logic [1:0]    bank_release_o;
   logic          rd_en_o;
   logic          rd_bank_o;
   logic [AW-1:0] rd_addr_o;
   logic [MW-1:0] rd_data_i;
   logic [MW-1:0] out_data_o;
   logic          out_valid_o;
   logic          out_ready_i;
   logic          out_last_o;
   logic [PW-1:0] out_pass_o;
   logic          busy_o;

   int nvec  = 0;
   int nfail = 0;
   int cyc   = 0;

   w_pp_reader dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bank_full_i    (bank_full_i),
      .bank_release_o (bank_release_o),
      .rd_en_o        (rd_en_o),
      .rd_bank_o      (rd_bank_o),
      .rd_addr_o      (rd_addr_o),
      .rd_data_i      (rd_data_i),
      .out_data_o     (out_data_o),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_last_o     (out_last_o),
      .out_pass_o     (out_pass_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) cyc <= cyc + 1;

   // Expected bank word: every 16-bit lane tagged with bank, lane and address
   function automatic logic [MW-1:0] word(input int b, input int a);
      logic [MW-1:0] w;
      w = '0;
      for (int k = 0; k < 16; k++) w[k*16 +: 16] = {4'hA, 4'(b), 4'(k), 4'(a)};
      return w;
   endfunction

   // Buffer model: data appears the cycle after the strobe, garbage otherwise
   always_ff @(posedge clk)
      rd_data_i <= rd_en_o ? word(int'(rd_bank_o), int'(rd_addr_o)) : {16{16'hDEAD}};

   task automatic chk(input string tag, input longint obs, input longint exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_d(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_release"}, longint'(bank_release_o), 0);
      chk({tag, "_rd_en"},   longint'(rd_en_o), 0);
      chk({tag, "_rd_bank"}, longint'(rd_bank_o), 0);
      chk({tag, "_rd_addr"}, longint'(rd_addr_o), 0);
      chk_d({tag, "_data"},  out_data_o, '0);
      chk({tag, "_valid"},   longint'(out_valid_o), 0);
      chk({tag, "_last"},    longint'(out_last_o), 0);
      chk({tag, "_pass"},    longint'(out_pass_o), 0);
      chk({tag, "_busy"},    longint'(busy_o), 0);
   endtask

   // One cycle after a release pulse: pulse gone and block idle
   task automatic idle_check(input string tag);
      @(negedge clk);
      #1;
      chk({tag, "_release_width"}, longint'(bank_release_o), 0);
      chk({tag, "_busy_low"},      longint'(busy_o), 0);
      chk({tag, "_idle_no_read"},  longint'(rd_en_o), 0);
   endtask

   // Follows one full bank replay until its release pulse
   task automatic stream(input int b, input bit bp, input int exp_t0, output int t_rel);
      int idx, iss, cnt_m, t0, t_fv, t_last;
      bit infl_m, prev_stall, done, pop;
      logic [MW-1:0] prev_d;
      idx = 0; iss = 0; cnt_m = 0; t0 = -1; t_fv = -1; t_last = -1; t_rel = -1;
      infl_m = 1'b0; prev_stall = 1'b0; done = 1'b0; prev_d = '0;
      for (int g = 0; g < 600 && !done; g++) begin
         @(negedge clk);
         out_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         pop = out_valid_o && out_ready_i;
         if (prev_stall) begin
            chk("hold_valid", longint'(out_valid_o), 1);
            chk_d("hold_data", out_data_o, prev_d);
         end
         if (rd_en_o) begin
            if (t0 < 0) t0 = cyc;
            chk("occupancy_lt2", longint'((cnt_m + int'(infl_m) - int'(pop)) < 2), 1);
            chk("rd_bank", longint'(rd_bank_o), longint'(b));
            chk("rd_addr", longint'(rd_addr_o), longint'(iss % 8));
            chk("rd_count", longint'(iss < 32), 1);
            iss++;
         end
         if (out_valid_o && t_fv < 0) t_fv = cyc;
         if (pop) begin
            chk_d("data", out_data_o, word(b, idx % 8));
            chk("pass", longint'(out_pass_o), longint'(idx / 8));
            chk("last", longint'(out_last_o), longint'((idx % 8) == 7));
            if (idx == 31) t_last = cyc;
            idx++;
         end
         if (bank_release_o != 2'b00) begin
            chk("release_bank", longint'(bank_release_o), (b == 0) ? 1 : 2);
            chk("words_before_release", longint'(idx), 32);
            t_rel = cyc;
            done = 1'b1;
            bank_full_i[b] = 1'b0;
         end
         cnt_m      = cnt_m + int'(infl_m) - int'(pop);
         infl_m     = rd_en_o;
         prev_stall = out_valid_o && !out_ready_i;
         prev_d     = out_data_o;
      end
      chk("released_in_time", longint'(done), 1);
      chk("first_read_cycle", longint'(t0), longint'(exp_t0));
      chk("first_valid_latency", longint'(t_fv), longint'(t0 + 2));
      if (!bp) begin
         chk("last_accept_cycle", longint'(t_last), longint'(t0 + 33));
         chk("release_cycle", longint'(t_rel), longint'(t_last + 2));
      end
   endtask

   initial begin
      int tr;
      int acc;
      rst_n       = 1'b0;
      bank_full_i = 2'b00;
      out_ready_i = 1'b1;

      // Reset state
      #1;
      chk_zero_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_busy", longint'(busy_o), 0);

      // Single bank, ready held high
      bank_full_i = 2'b01;
      stream(0, 1'b0, cyc + 1, tr);
      idle_check("single");

      // Backpressure on bank 1 (next in turn)
      bank_full_i = 2'b10;
      stream(1, 1'b1, cyc + 1, tr);
      idle_check("backpressure");
      out_ready_i = 1'b1;

      // Both banks full: strict alternation with one IDLE cycle between
      @(negedge clk);
      bank_full_i = 2'b11;
      stream(0, 1'b0, cyc + 1, tr);
      idle_check("alt0");
      stream(1, 1'b0, tr + 2, tr);
      idle_check("alt1");

      // Wrong bank first after reset: bank 1 must wait for bank 0
      @(negedge clk);
      rst_n = 1'b0;
      bank_full_i = 2'b10;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         chk("wrong_bank_no_read", longint'(rd_en_o), 0);
         chk("wrong_bank_idle", longint'(busy_o), 0);
      end
      bank_full_i = 2'b11;
      stream(0, 1'b0, cyc + 1, tr);
      idle_check("wb0");
      stream(1, 1'b0, tr + 2, tr);
      idle_check("wb1");

      // Reset in the middle of a stream aborts without a release
      @(negedge clk);
      bank_full_i = 2'b01;
      acc = 0;
      for (int g = 0; g < 100 && acc < 13; g++) begin
         @(negedge clk);
         #1;
         if (out_valid_o && out_ready_i) acc++;
      end
      chk("partial_words", longint'(acc), 13);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("abort");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("abort_no_release", longint'(bank_release_o), 0);
      end
      rst_n = 1'b1;
      stream(0, 1'b0, cyc + 1, tr);
      idle_check("restart");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/w_pp_reader.md
# w_pp_reader

Read-side sequencer for the West ping-pong buffer feeding the systolic matmul cores. It waits for the writer to mark a bank full, then streams the bank out word by word. Each bank is replayed once per output column block (COL_Y passes), with valid/ready backpressure toward the cores. When the bank has been fully consumed, the block hands it back to the writer.

## Interface
- WIDTH, 16: fixed-point word width (Q8.8 in this design).
- CHUNK_SIZE, 4: words per core chunk.
- NUM_CORES_A, 2: core rows.
- NUM_CORES_B, 2: core columns.
- COL_X, 4: inner dimension in blocks.
- TOTAL_INPUT_W, 2: input words per column block.
- COL_Y, 4: number of replay passes per bank.
- MODULE_WIDTH, WIDTH*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B (256): bank word width.
- TOTAL_DEPTH, COL_X*TOTAL_INPUT_W (8): words per bank.
- ADDR_WIDTH, $clog2(TOTAL_DEPTH) (3): address width.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- bank_full_i, in, 2: level from the writer; bit b set means bank b holds a complete matrix.
- bank_release_o, out, 2: one-cycle pulse on bit b when the reader has finished with bank b.
- rd_en_o, out, 1: buffer read strobe.
- rd_bank_o, out, 1: bank select.
- rd_addr_o, out, ADDR_WIDTH: word address.
- rd_data_i, in, MODULE_WIDTH: read data, valid exactly one cycle after rd_en_o.
- out_data_o, out, MODULE_WIDTH: word to the cores.
- out_valid_o, out, 1: output valid.
- out_ready_i, in, 1: output ready.
- out_last_o, out, 1: marks the last word (addr TOTAL_DEPTH-1) of each pass.
- out_pass_o, out, $clog2(COL_Y): pass index of the current output word.
- busy_o, out, 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: the bank pointer `cur` selects the bank to serve. Go to READ when bank_full_i[cur]=1.
  - READ: issue reads for addr 0..TOTAL_DEPTH-1, repeated for pass 0..COL_Y-1. After the final read is issued, go to DRAIN.
  - DRAIN: wait until the last word has been accepted (valid&&ready with out_last_o on pass COL_Y-1) and nothing remains in flight or in the FIFO. Then go to RELEASE.
  - RELEASE: pulse bank_release_o[cur] for one cycle, toggle `cur`, return to IDLE.
- Banks are served in strict alternation starting at bank 0. A full bank that is not `cur` waits its turn.
- Output path is a 2-entry FIFO. Data, pass tag and last tag are captured from rd_data_i on the cycle after rd_en_o.
- Read issue rule: rd_en_o=1 in READ iff (fifo_count + inflight − pop) < 2, where pop = out_valid_o && out_ready_i. At most one read is in flight. This sustains one word per cycle when out_ready_i is held high.
- Address and pass counters advance only on an issued read. Address wraps TOTAL_DEPTH-1→0 and increments the pass counter.
- out_data_o must hold stable while out_valid_o=1 and out_ready_i=0.
- A bank_full_i[cur] drop during READ or DRAIN is ignored: the writer contract forbids it.
- Both banks full at once: serve `cur`, then the other bank back-to-back with one IDLE cycle between.

## Timing
- Reset values: state=IDLE, cur=0, counters=0, FIFO empty, all outputs 0.
- A reset assertion mid-bank aborts immediately. No release pulse is issued, and the bank pointer returns to 0.
- IDLE sees bank_full_i[cur]=1 in cycle t → READ at t+1 with rd_en_o=1, addr 0.
- Read latency: rd_en_o at cycle t → out_valid_o at t+2 if the FIFO was empty.
- Streaming with out_ready_i=1: TOTAL_DEPTH*COL_Y consecutive valid words. The last is accepted at cycle t0+1+TOTAL_DEPTH*COL_Y, where t0 is the first READ cycle.
- bank_release_o pulses 2 cycles after the last acceptance (one DRAIN→RELEASE transition, one RELEASE cycle). busy_o falls the cycle after the pulse.

## Test plan
- Single bank, ready always 1: set bank_full_i=01.
  - Expect 32 words in addr order 0..7 ×4, each pass exactly the bank contents.
  - out_last_o on words 7, 15, 23, 31; out_pass_o stepping 0..3.
  - One bank_release_o=01 pulse, then IDLE.
- Backpressure: toggle out_ready_i randomly (about 50%).
  - No word lost or duplicated.
  - out_data_o stable while stalled.
  - rd_en_o never fires when the FIFO plus in-flight read would exceed 2.
- Alternation: set bank_full_i=11 with distinct contents.
  - Bank 0 streams fully and releases (pulse 01), then bank 1 streams (pulse 10).
  - Exactly one IDLE cycle between them.
- Wrong bank first: bank_full_i=10 after reset.
  - No reads issued for 20 cycles.
  - Raise bit 0 → bank 0 is served first.
- Reset mid-stream: assert rst_n=0 at word 13.
  - All outputs 0 asynchronously; no release pulse.
  - After reset with bank_full_i=01, a clean 32-word stream restarts at addr 0, pass 0.
